branch_predict_table: RTL and testbench
=======================================

Name: branch_predict_table

Overview:
- Parametrised successor to the single 2-bit branch predictor: a pattern history table (PHT) of N-bit saturating counters, indexed by fetch PC.
- Sits in IF. A lookup issued with the fetch PC returns a registered taken/not-taken prediction one cycle later.
- EX resolves each branch and writes its outcome back through a separate update port.
- Includes a saturating mispredict performance counter.

Parameters:
- PC_WIDTH, 32, fetch/update PC width.
- INDEX_BITS, 6, log2 of table entries (default 64 entries).
- CNT_BITS, 2, saturating counter width; legal range 2..4.
- PC_LSB, 2, lowest PC bit used for indexing (word-aligned instructions).
- PERF_BITS, 16, width of the mispredict counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- lookup_valid  input  1  IF lookup request this cycle.
- lookup_pc  input  PC_WIDTH  fetch PC.
- pred_valid  output  1  registered lookup_valid.
- pred_taken  output  1  prediction: MSB of the selected counter.
- pred_idx  output  INDEX_BITS  table index used; carried down the pipe and returned as upd_idx.
- upd_valid  input  1  resolved conditional branch this cycle.
- upd_idx  input  INDEX_BITS  index captured at lookup.
- upd_taken  input  1  actual branch outcome.
- upd_mispredict  input  1  EX detected a misprediction; only qualified by upd_valid.
- perf_clear  input  1  synchronous clear of the perf counter.
- mispredict_cnt  output  PERF_BITS  saturating mispredict count.

Behaviour:
- Reset (rst=0, asynchronous):
  - Every counter is set to weakly-not-taken, value 2^(CNT_BITS-1)-1 (01 for CNT_BITS=2).
  - pred_valid=0, pred_taken=0, pred_idx=0, mispredict_cnt=0, history register (if present)=0.
  - Reset asserted mid-operation discards any in-flight lookup.
- Index: idx = lookup_pc[PC_LSB+INDEX_BITS-1 : PC_LSB].
- Lookup latency is one cycle. On the edge where lookup_valid=1:
  - pred_valid<=1, pred_idx<=idx, pred_taken<=MSB(table[idx]).
  - When lookup_valid=0: pred_valid<=0, pred_taken<=0, pred_idx holds its value.
- Update, on the edge where upd_valid=1, writes table[upd_idx]:
  - upd_taken=1: counter+1, saturating at 2^CNT_BITS-1.
  - upd_taken=0: counter-1, saturating at 0.
  - Counter state machine for CNT_BITS=2: SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11); taken moves right, not-taken moves left; saturates at both ends.
  - upd_valid=0: no table change. Non-branch cycles never disturb state.
- Simultaneous lookup and update to the same index (write-first bypass): pred_taken reflects the post-update counter value.
- Simultaneous lookup and update to different indices are independent.
- Perf counter:
  - Increments on upd_valid & upd_mispredict and saturates at all-ones (no wrap).
  - perf_clear=1 forces 0 at the next edge; clear wins over a same-cycle increment.
- Widths: all counter arithmetic is performed at CNT_BITS+1 bits and clamped; no overflow path exists.

Optional Feature:
- Macro: BRANCH_PREDICT_GSHARE_EN.
- Defined: adds an INDEX_BITS global history register (ghr).
  - Lookup index = pc index bits XOR ghr, and pred_idx reports this XORed index.
  - On upd_valid, ghr <= {ghr[INDEX_BITS-2:0], upd_taken}.
  - The ghr shift and a same-cycle lookup use the pre-shift ghr.
  - ghr resets to 0.
- Undefined: no ghr logic; pure bimodal indexing as above.
- The port list is identical in both builds.

Test Plan:
- Reset, then lookup PC=0x0000_0040 -> next cycle pred_valid=1, pred_taken=0, pred_idx=0x10.
- Two updates taken to idx 0x10, then lookup 0x40 -> pred_taken=1. Two more taken, then one not-taken -> counter 10, still pred_taken=1. Saturation at 11 is confirmed via a further taken, which leaves the counter at 11.
- Lookup 0x40 and update idx 0x10 taken in the same cycle, starting from counter 01 -> pred_taken=1 (bypass). Same stimulus with update idx 0x11 -> pred_taken=0.
- Drive rst=0 asynchronously mid-cycle after training idx 0x10 to 11 -> all outputs 0 immediately. Lookup 0x40 after release -> pred_taken=0.
- 0xFFFF + 3 mispredicting updates with PERF_BITS=16 -> mispredict_cnt=0xFFFF. perf_clear together with a mispredict -> 0.
- With BRANCH_PREDICT_GSHARE_EN, INDEX_BITS=6: updates taken,taken (ghr=0b000011), then lookup PC=0x40 -> pred_idx=0x13.

Source files
------------

// File: rtl/branch_predict_table.sv
// Pattern history table of saturating counters indexed by fetch PC, with a saturating mispredict counter.
// Optional gshare indexing (global history XOR PC bits) is enabled by defining BRANCH_PREDICT_GSHARE_EN.
module branch_predict_table #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned CNT_BITS   = 2,
    parameter int unsigned PC_LSB     = 2,
    parameter int unsigned PERF_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_idx,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_idx,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict,
    input  logic                  perf_clear,
    output logic [PERF_BITS-1:0]  mispredict_cnt
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam logic [CNT_BITS:0]   CNT_MAX = {1'b0, {CNT_BITS{1'b1}}};
    localparam logic [CNT_BITS-1:0] CNT_WNT = {1'b0, {(CNT_BITS-1){1'b1}}};

    logic [CNT_BITS-1:0]   table_q [ENTRIES];
    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0] pred_idx_q, pred_idx_d;
    logic [PERF_BITS-1:0]  perf_q, perf_d;

    logic [INDEX_BITS-1:0] lk_idx_c;
    logic [CNT_BITS-1:0]   upd_cnt_c;
    logic [CNT_BITS-1:0]   lk_cnt_c;
    logic                  lookup_pc_unused;

    // Only the index field of the PC is consumed; fold the rest to keep every bit observed.
    assign lookup_pc_unused = ^lookup_pc;

    // One saturating step, computed one bit wider than the counter and clamped.
    function automatic logic [CNT_BITS-1:0] cnt_step(input logic [CNT_BITS-1:0] cnt,
                                                     input logic taken);
        logic [CNT_BITS:0] wide;
        wide = {1'b0, cnt};
        if (taken) begin
            wide = wide + (CNT_BITS+1)'(1);
            if (wide > CNT_MAX) wide = CNT_MAX;
        end else if (wide != '0) begin
            wide = wide - (CNT_BITS+1)'(1);
        end
        return wide[CNT_BITS-1:0];
    endfunction

`ifdef BRANCH_PREDICT_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q, ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) ghr_d = {ghr_q[INDEX_BITS-2:0], upd_taken};
    end

    // Lookup sees the pre-shift history even when an update lands in the same cycle.
    assign lk_idx_c = lookup_pc[PC_LSB +: INDEX_BITS] ^ ghr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ghr_q <= '0;
        else      ghr_q <= ghr_d;
    end
`else
    assign lk_idx_c = lookup_pc[PC_LSB +: INDEX_BITS];
`endif

    assign upd_cnt_c = cnt_step(table_q[upd_idx], upd_taken);

    // Write-first bypass: a same-index update is visible to the concurrent lookup.
    assign lk_cnt_c = (upd_valid && (upd_idx == lk_idx_c)) ? upd_cnt_c : table_q[lk_idx_c];

    always_comb begin
        pred_valid_d = lookup_valid;
        pred_taken_d = 1'b0;
        pred_idx_d   = pred_idx_q;
        if (lookup_valid) begin
            pred_taken_d = lk_cnt_c[CNT_BITS-1];
            pred_idx_d   = lk_idx_c;
        end
    end

    always_comb begin
        perf_d = perf_q;
        if (perf_clear) begin
            perf_d = '0;
        end else if (upd_valid && upd_mispredict && (perf_q != '1)) begin
            perf_d = perf_q + PERF_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            table_q <= '{default: CNT_WNT};
        end else if (upd_valid) begin
            table_q[upd_idx] <= upd_cnt_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
            perf_q       <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_idx_q   <= pred_idx_d;
            perf_q       <= perf_d;
        end
    end

    assign pred_valid     = pred_valid_q;
    assign pred_taken     = pred_taken_q;
    assign pred_idx       = pred_idx_q;
    assign mispredict_cnt = perf_q;

endmodule

// File: tb/tb_branch_predict_table.sv
// Directed self-checking bench for branch_predict_table (default parameters).
// Build with BRANCH_PREDICT_GSHARE_EN defined to exercise the gshare indexing case instead of bimodal.
module tb_branch_predict_table;

    logic        clk;
    logic        rst;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [5:0]  pred_idx;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic        upd_mispredict;
    logic        perf_clear;
    logic [15:0] mispredict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    branch_predict_table dut (
        .clk            (clk),
        .rst            (rst),
        .lookup_valid   (lookup_valid),
        .lookup_pc      (lookup_pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_idx       (pred_idx),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .perf_clear     (perf_clear),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus; valids and clear drop after the edge.
    task automatic cyc(input logic lv, input logic [31:0] pc, input logic uv,
                       input logic [5:0] idx, input logic tk, input logic mis,
                       input logic clr);
        lookup_valid   = lv;
        lookup_pc      = pc;
        upd_valid      = uv;
        upd_idx        = idx;
        upd_taken      = tk;
        upd_mispredict = mis;
        perf_clear     = clr;
        step();
        lookup_valid   = 1'b0;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        perf_clear     = 1'b0;
    endtask

    task automatic check_pred(input string tag, input logic pv, input logic pt, input logic [5:0] pi);
        check({tag, ".valid"}, 32'(pred_valid), 32'(pv));
        check({tag, ".taken"}, 32'(pred_taken), 32'(pt));
        check({tag, ".idx"},   32'(pred_idx),   32'(pi));
    endtask

    initial begin
        rst            = 1'b0;
        lookup_valid   = 1'b0;
        lookup_pc      = '0;
        upd_valid      = 1'b0;
        upd_idx        = '0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
        perf_clear     = 1'b0;
        #2;
        check_pred("reset", 1'b0, 1'b0, 6'h00);
        check("reset.perf", 32'(mispredict_cnt), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

`ifdef BRANCH_PREDICT_GSHARE_EN
        cyc(1'b0, 32'h0, 1'b1, 6'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 6'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        check_pred("gshare", 1'b1, 1'b0, 6'h13);
`else
        // First lookup sees weakly-not-taken.
        cyc(1'b1, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        check_pred("lk_first", 1'b1, 1'b0, 6'h10);
        cyc(1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        check_pred("lk_idle", 1'b0, 1'b0, 6'h10);

        // Train 01 -> 10 -> 11.
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 6'h10, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        check_pred("train2", 1'b1, 1'b1, 6'h10);

        // Saturate, then one not-taken lands at 10.
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 6'h10, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 6'h10, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        check_pred("sat_nt", 1'b1, 1'b1, 6'h10);

        // 10 -> 11, taken at 11 holds 11; two not-taken then give 10 then 01.
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 6'h10, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 6'h10, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        check_pred("sat_hold", 1'b1, 1'b1, 6'h10);
        cyc(1'b0, 32'h0, 1'b1, 6'h10, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        check_pred("back_wnt", 1'b1, 1'b0, 6'h10);

        // Bypass: counter 01, same-cycle taken update makes 10.
        cyc(1'b1, 32'h40, 1'b1, 6'h10, 1'b1, 1'b0, 1'b0);
        check_pred("bypass_same", 1'b1, 1'b1, 6'h10);
        cyc(1'b0, 32'h0, 1'b1, 6'h10, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h40, 1'b1, 6'h11, 1'b1, 1'b0, 1'b0);
        check_pred("bypass_diff", 1'b1, 1'b0, 6'h10);
        cyc(1'b1, 32'h44, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        check_pred("idx11_upd", 1'b1, 1'b1, 6'h11);

        // upd_valid low with taken/mispredict asserted must not disturb anything.
        repeat (3) cyc(1'b0, 32'h0, 1'b0, 6'h10, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        check_pred("no_upd", 1'b1, 1'b0, 6'h10);
        check("no_upd.perf", 32'(mispredict_cnt), 32'h0);

        // Train idx 0x10 to 11 while counting two mispredicts, then async reset mid-cycle.
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 6'h10, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        check_pred("pre_rst", 1'b1, 1'b1, 6'h10);
        check("pre_rst.perf", 32'(mispredict_cnt), 32'h2);
        lookup_valid = 1'b1;
        lookup_pc    = 32'h40;
        #3 rst = 1'b0;
        #1;
        check_pred("async_rst", 1'b0, 1'b0, 6'h00);
        check("async_rst.perf", 32'(mispredict_cnt), 32'h0);
        lookup_valid = 1'b0;
        #1 rst = 1'b1;
        step();
        check_pred("rst_release", 1'b0, 1'b0, 6'h00);
        cyc(1'b1, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        check_pred("post_rst", 1'b1, 1'b0, 6'h10);
`endif

        // Perf counter saturation, then clear beating a same-cycle increment.
        upd_valid      = 1'b1;
        upd_idx        = 6'h3F;
        upd_taken      = 1'b1;
        upd_mispredict = 1'b1;
        repeat (32'hFFFF + 3) @(posedge clk);
        #1;
        check("perf_sat", 32'(mispredict_cnt), 32'hFFFF);
        perf_clear = 1'b1;
        step();
        check("perf_clear", 32'(mispredict_cnt), 32'h0);
        perf_clear = 1'b0;
        step();
        check("perf_inc", 32'(mispredict_cnt), 32'h1);
        upd_valid = 1'b0;
        step();
        check("perf_unqual", 32'(mispredict_cnt), 32'h1);
        upd_mispredict = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
